rf_ctx_xfer: RTL and testbench
==============================

RF_CTX_XFER -- requirements
Module: rf_ctx_xfer

Interface
REQ-001 SHALL have parameter NREG, default 16, meaning the register count in the attached register-file memory.
REQ-002 SHALL have parameter AW, default 4, meaning the register address width.
REQ-003 SHALL have parameter DW, default 17, meaning the register data width.
REQ-004 Ports are listed below; one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on posedge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 save_req  input  1  start a save, streaming registers 1..NREG-1 out.
REQ-008 restore_req  input  1  start a restore, writing streamed words to registers 1..NREG-1.
REQ-009 busy  output  1  high while a save or restore is in progress.
REQ-010 done  output  1  one-cycle pulse when an operation completes.
REQ-011 rf_raddr  output  AW  read address to the memory read port.
REQ-012 rf_rdata  input  DW  memory read data, valid one clk cycle after rf_raddr is presented.
REQ-013 rf_waddr  output  AW  write address to the memory write port.
REQ-014 rf_wdata  output  DW  write data to the memory write port.
REQ-015 rf_we  output  1  write enable to the memory write port.
REQ-016 out_data / out_valid / out_ready  output / output / input  DW / 1 / 1  save stream; transfer when valid&&ready.
REQ-017 in_data / in_valid / in_ready  input / input / output  DW / 1 / 1  restore stream; transfer when valid&&ready.

Function
REQ-018 SHALL implement the FSM states IDLE, SAVE, SAVE_DRAIN, RESTORE and FINISH.
REQ-019 In IDLE, save_req SHALL cause a transition to SAVE, and restore_req SHALL cause a transition to RESTORE; if both are asserted in the same cycle, save wins.
REQ-020 While busy, save_req and restore_req SHALL be ignored.
REQ-021 SAVE: rf_raddr SHALL step 1..NREG-1, advancing only when the 2-entry output skid buffer can accept the word returning next cycle.
REQ-022 The skid buffer SHALL capture rf_rdata one cycle after each issued address, so words leave in ascending register order with no loss or duplication.
REQ-023 With out_ready held high, save SHALL sustain one word per cycle, and the first out_valid SHALL occur 2 cycles after the save_req cycle.
REQ-024 out_data SHALL be held stable while out_valid && !out_ready.
REQ-025 After address NREG-1 is issued, the FSM SHALL go to SAVE_DRAIN and stay there until the buffer is empty.
REQ-026 RESTORE: in_ready SHALL be 1 whenever in the RESTORE state.
REQ-027 Each accepted word k (k = 0..NREG-2) SHALL be registered and appear in the following cycle as rf_we=1, rf_waddr=k+1, rf_wdata=word.
REQ-028 After the (NREG-1)th accepted word, in_ready SHALL drop in the next cycle and the FSM SHALL go to FINISH.
REQ-029 rf_we SHALL never be asserted with rf_waddr=0 and SHALL never be asserted outside the cycle following an accepted restore word.
REQ-030 FINISH SHALL last one cycle, pulse done=1, and return to IDLE; busy SHALL be 0 in the done cycle.
REQ-031 Address counters SHALL be AW+1 bits so that the terminal compare does not wrap; rf_raddr and rf_waddr are the low AW bits.
REQ-032 in_valid while not in RESTORE SHALL be ignored, with in_ready=0.
REQ-033 A save issued the cycle after a restore's done SHALL read the freshly written values, since the memory writes on negedge ahead of the next read.

Reset
REQ-034 On rst_n=0 at posedge, the FSM SHALL go to IDLE and the counters and skid buffer SHALL clear.
REQ-035 Reset values SHALL be busy=0, done=0, out_valid=0, in_ready=0, rf_we=0, rf_raddr=0, rf_waddr=0, rf_wdata=0, out_data=0.
REQ-036 Reset mid-operation SHALL discard partial data and SHALL issue no further writes in the following cycle.

Structure
REQ-037 A shared package SHALL hold the state enum (xfer_state_t) and the constants NREG, AW and DW, shared with the register-file modules.
REQ-038 The 2-entry skid buffer SHALL be a sub-module named rf_skid_buf with DW-wide valid/ready on both sides; everything else is flat.

Verification
REQ-039 Save with out_ready=1 and registers preloaded with value=addr*3: out_data SHALL be 3,6,...,45 on 15 consecutive cycles, done one cycle after the buffer drains, busy=0 in the done cycle.
REQ-040 Save with out_ready toggling 1,0,0,1 repeating: all 15 words SHALL arrive in order, with no duplication and out_data stable during stalls.
REQ-041 Restore with in_data=0x1FFFF-k and in_valid gapped randomly: rf_we SHALL pulse exactly 15 times to addresses 1..15, never to 0, followed by a single done pulse; a subsequent save SHALL read the written values back.
REQ-042 save_req and restore_req asserted in the same IDLE cycle: a save SHALL run; restore_req asserted during the save SHALL be ignored.
REQ-043 rst_n=0 for one cycle after the 7th restore word: rf_we=0 the next cycle, the FSM in IDLE, and registers 8..15 unchanged.
REQ-044 Back-to-back restore then save, with the save_req asserted in the restore's done cycle+1: the saved stream SHALL equal the restored stream.

Source files
------------

// File: rtl/rf_ctx_xfer_pkg.sv
// Shared constants and FSM state type for the register-file context save/restore engine.
package rf_ctx_xfer_pkg;
  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 17;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    SAVE_DRAIN,
    RESTORE,
    FINISH
  } xfer_state_t;
endpackage

// File: rtl/rf_skid_buf.sv
// Two-entry first-word-fall-through buffer: an arriving word passes straight through when empty and ready.
// Zero-cycle latency on bypass; in_rdy_o drops only when both entries are held.
module rf_skid_buf #(
  parameter int DW = rf_ctx_xfer_pkg::DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_vld_i,
  input  logic [DW-1:0] in_dat_i,
  output logic          in_rdy_o,
  output logic          out_vld_o,
  output logic [DW-1:0] out_dat_o,
  input  logic          out_rdy_i,
  output logic [1:0]    level_o
);
  logic [DW-1:0] mem_q [2];
  logic          rd_q;
  logic          wr_q;
  logic [1:0]    cnt_q;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty     = (cnt_q == 2'd0);
  assign in_rdy_o  = (cnt_q != 2'd2);
  assign out_vld_o = !empty || in_vld_i;
  assign out_dat_o = !empty ? mem_q[rd_q] : (in_vld_i ? in_dat_i : '0);
  assign level_o   = cnt_q;
  // A word only needs storing if it cannot leave in the cycle it arrives.
  assign push      = in_vld_i && in_rdy_o && !(empty && out_rdy_i);
  assign pop       = !empty && out_rdy_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= in_dat_i;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/rf_ctx_xfer.sv
// Streams registers 1..NREG-1 out of (save) or into (restore) a register file with a 1-cycle read port.
// First saved word 2 cycles after save_req; reads are throttled so the skid buffer never overflows.
module rf_ctx_xfer #(
  parameter int NREG = rf_ctx_xfer_pkg::NREG,
  parameter int AW   = rf_ctx_xfer_pkg::AW,
  parameter int DW   = rf_ctx_xfer_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          save_req,
  input  logic          restore_req,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_we,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready
);
  import rf_ctx_xfer_pkg::*;

  localparam logic [AW:0] LAST_R = (AW+1)'(NREG - 1);
  localparam logic [AW:0] LAST_W = (AW+1)'(NREG - 2);

  xfer_state_t   state_q, state_d;
  logic [AW:0]   raddr_q, raddr_d;
  logic [AW:0]   waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          pend_q, pend_d;

  logic [1:0]    level;
  logic          skid_in_rdy;
  logic          issue;
  logic          in_fire;
  logic          out_fire;
  logic          drained;

  rf_skid_buf #(.DW(DW)) u_skid (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .in_vld_i  (pend_q),
    .in_dat_i  (rf_rdata),
    .in_rdy_o  (skid_in_rdy),
    .out_vld_o (out_valid),
    .out_dat_o (out_data),
    .out_rdy_i (out_ready),
    .level_o   (level)
  );

  // Words held plus the word in flight from the memory must leave room for one more.
  assign issue    = (state_q == SAVE) && skid_in_rdy &&
                    ((level == 2'd0) || ((level == 2'd1) && !pend_q));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign drained  = ({1'b0, level} + {2'b00, pend_q}) == {2'b00, out_fire};

  assign in_ready = (state_q == RESTORE);
  assign busy     = (state_q == SAVE) || (state_q == SAVE_DRAIN) || (state_q == RESTORE);
  assign done     = (state_q == FINISH);
  assign rf_raddr = raddr_q[AW-1:0];
  assign rf_waddr = waddr_q[AW-1:0];
  assign rf_wdata = wdata_q;
  assign rf_we    = we_q;

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    pend_d  = issue;
    case (state_q)
      IDLE: begin
        if (save_req) begin
          state_d = SAVE;
          raddr_d = (AW+1)'(1);
        end else if (restore_req) begin
          state_d = RESTORE;
          waddr_d = '0;
        end
      end
      SAVE: begin
        if (issue) begin
          raddr_d = raddr_q + 1'b1;
          if (raddr_q == LAST_R) state_d = SAVE_DRAIN;
        end
      end
      SAVE_DRAIN: if (drained) state_d = FINISH;
      RESTORE: begin
        if (in_fire) begin
          we_d    = 1'b1;
          wdata_d = in_data;
          waddr_d = waddr_q + 1'b1;
          if (waddr_q == LAST_W) state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: tb/tb_rf_ctx_xfer.sv
// Directed bench for rf_ctx_xfer with a behavioural register file (posedge read, negedge write).
module tb_rf_ctx_xfer;
  import rf_ctx_xfer_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          save_req = 1'b0;
  logic          restore_req = 1'b0;
  logic          busy, done;
  logic [AW-1:0] rf_raddr, rf_waddr;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] rf_wdata;
  logic          rf_we;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;

  logic [DW-1:0] mem [NREG];
  logic          preload = 1'b1;
  int            wr_cnt = 0;
  int            bad_wr = 0;
  logic [DW-1:0] exp_w [128];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  rf_ctx_xfer #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .save_req    (save_req),
    .restore_req (restore_req),
    .busy        (busy),
    .done        (done),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_we       (rf_we),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready)
  );

  always @(negedge clk) begin
    if (preload) for (int i = 0; i < NREG; i++) mem[i] <= DW'(i * 3);
    if (rf_we) begin
      mem[rf_waddr] <= rf_wdata;
      wr_cnt <= wr_cnt + 1;
      if (rf_waddr == '0) bad_wr <= bad_wr + 1;
    end
  end

  always @(posedge clk) rf_rdata <= mem[rf_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] wdat(input logic [DW-1:0] base, input bit up, input int k);
    return up ? base + DW'(k) : base - DW'(k);
  endfunction

  // toggle: out_ready follows 1,0,0,1; both: restore_req rides along with save_req and again mid-save
  task automatic do_save(input string nm, input bit toggle, input bit both);
    int cyc, got, base_wr;
    bit fin, stall_prev;
    logic [DW-1:0] held;
    logic [3:0] pat;
    pat = 4'b1001;
    step();
    base_wr = wr_cnt;
    save_req = 1'b1;
    restore_req = both;
    out_ready = 1'b1;
    #1;
    chk({nm, " idle before"}, {30'd0, busy, done}, 32'd0);
    cyc = 0; got = 0; fin = 1'b0; stall_prev = 1'b0; held = '0;
    while (!fin && cyc < 100) begin
      step();
      cyc++;
      save_req = 1'b0;
      restore_req = both && (cyc == 5);
      out_ready = toggle ? pat[cyc % 4] : 1'b1;
      #1;
      if (both) chk({nm, " in_ready"}, in_ready, 0);
      if (stall_prev) begin
        chk({nm, " stall valid"}, out_valid, 1);
        chk({nm, " stall hold"}, out_data, held);
      end
      if (out_valid && out_ready) begin
        chk({nm, " word"}, out_data, exp_w[got + 1]);
        if (!toggle) chk({nm, " word cycle"}, cyc, got + 2);
        got++;
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
      if (done) begin
        fin = 1'b1;
        chk({nm, " busy at done"}, busy, 0);
        chk({nm, " word count"}, got, NREG - 1);
        if (!toggle) chk({nm, " done cycle"}, cyc, 17);
      end
    end
    chk({nm, " finished"}, fin, 1);
    chk({nm, " no writes"}, wr_cnt - base_wr, 0);
    out_ready = 1'b1;
    restore_req = 1'b0;
  endtask

  // stop_at >= 0 leaves the task right after that many words were accepted
  task automatic do_restore(input string nm, input logic [DW-1:0] base, input bit up, input int stop_at);
    int k, cyc;
    bit acc_prev, fin;
    step();
    restore_req = 1'b1;
    in_valid = 1'b0;
    k = 0; cyc = 0; acc_prev = 1'b0; fin = 1'b0;
    while (!fin && cyc < 300) begin
      step();
      cyc++;
      restore_req = 1'b0;
      in_valid = (k < NREG - 1) && (stop_at < 0 || k < stop_at) && ($urandom_range(0, 2) != 0);
      in_data = wdat(base, up, k);
      #1;
      if (acc_prev) begin
        chk({nm, " we"}, rf_we, 1);
        chk({nm, " waddr"}, rf_waddr, k);
        chk({nm, " wdata"}, rf_wdata, wdat(base, up, k - 1));
      end else begin
        chk({nm, " idle we"}, rf_we, 0);
      end
      acc_prev = in_valid && in_ready;
      if (acc_prev) k++;
      if (done) begin
        fin = 1'b1;
        chk({nm, " in_ready at done"}, in_ready, 0);
        chk({nm, " accepted"}, k, NREG - 1);
      end
      if (stop_at >= 0 && acc_prev && k == stop_at) fin = 1'b1;
    end
    chk({nm, " finished"}, fin, 1);
  endtask

  initial begin
    int base0;
    step();
    step();
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset rf_we", rf_we, 0);
    chk("reset rf_raddr", rf_raddr, 0);
    chk("reset rf_waddr", rf_waddr, 0);
    chk("reset rf_wdata", rf_wdata, 0);
    chk("reset out_data", out_data, 0);
    rst_n = 1'b1;
    step();
    preload = 1'b0;

    for (int i = 1; i < NREG; i++) exp_w[i] = DW'(i * 3);
    do_save("save ready", 1'b0, 1'b0);
    do_save("save toggle", 1'b1, 1'b0);

    base0 = wr_cnt;
    do_restore("restore", 17'h1FFFF, 1'b0, -1);
    for (int i = 1; i < NREG; i++) exp_w[i] = 17'h1FFFF - DW'(i - 1);
    do_save("readback", 1'b0, 1'b0);
    chk("restore write count", wr_cnt - base0, NREG - 1);
    chk("write to addr 0", bad_wr, 0);

    step();
    in_valid = 1'b1;
    in_data = 17'h12345;
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      chk("idle in_ready", in_ready, 0);
      chk("idle rf_we", rf_we, 0);
      chk("idle busy", busy, 0);
    end
    in_valid = 1'b0;

    do_save("both req", 1'b0, 1'b1);
    step();
    #1;
    chk("restore ignored", busy, 0);

    do_restore("mid restore", 17'h00AAA, 1'b1, 7);
    step();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst cycle we", rf_we, 1);
    chk("rst cycle waddr", rf_waddr, 7);
    step();
    rst_n = 1'b1;
    #1;
    chk("post rst we", rf_we, 0);
    chk("post rst busy", busy, 0);
    chk("post rst in_ready", in_ready, 0);
    chk("post rst done", done, 0);
    for (int i = 1; i < NREG; i++)
      exp_w[i] = (i <= 7) ? 17'h00AAA + DW'(i - 1) : 17'h1FFFF - DW'(i - 1);
    do_save("after reset", 1'b0, 1'b0);
    chk("final addr 0 writes", bad_wr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
